// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes pwm_in, measures rise-to-rise period and high time,
// and derives floor(high*100/period) with a restoring divider. Flags timeout and overrun.
module pwm_capture #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [6:0]           duty_pct,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 overrun
);

  localparam int DVD_W  = CNT_WIDTH + 7;
  localparam int ITER_W = $clog2(DVD_W);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(DVD_W - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sDly;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_hcnt;
  logic [DVD_W-1:0]       r_dvd;
  logic [CNT_WIDTH-1:0]   r_rem;
  logic [CNT_WIDTH-1:0]   r_divisor;
  logic [CNT_WIDTH-1:0]   r_pendHigh;
  logic [ITER_W-1:0]      r_iter;
  state_t                 r_state;

  state_t                 w_nextState;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_load;
  logic                   w_divStep;
  logic                   w_divDone;
  logic                   w_timeoutHit;
  logic                   w_overrunHit;
  logic [DVD_W-1:0]       w_highExt;
  logic [DVD_W-1:0]       w_scaled;
  logic [CNT_WIDTH:0]     w_remShift;
  logic [CNT_WIDTH-1:0]   w_remSub;
  logic                   w_ge;
  logic [CNT_WIDTH-1:0]   w_remNext;
  logic [DVD_W-1:0]       w_quoNext;

  // The synchronizer keeps running while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_sDly <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_sDly <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_sDly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= CNT_WIDTH'(1);
      r_hcnt <= CNT_WIDTH'(1);
    end else begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_s && (r_hcnt != CNT_MAX)) r_hcnt <= r_hcnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (!enable) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_rise) w_nextState = MEASURE;
        MEASURE: begin
          if (w_rise)                 w_nextState = DIVIDE;
          else if (r_cnt == CNT_MAX)  w_nextState = IDLE;
        end
        DIVIDE:  if (r_iter == LAST_ITER) w_nextState = MEASURE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    w_load       = 1'b0;
    w_divStep    = 1'b0;
    w_divDone    = 1'b0;
    w_timeoutHit = 1'b0;
    w_overrunHit = 1'b0;
    if (enable) begin
      w_load       = (r_state == MEASURE) && w_rise;
      w_timeoutHit = (r_state == MEASURE) && !w_rise && (r_cnt == CNT_MAX);
      w_divStep    = (r_state == DIVIDE);
      w_divDone    = (r_state == DIVIDE) && (r_iter == LAST_ITER);
      w_overrunHit = (r_state == DIVIDE) && w_rise;
    end
  end

  // high*100 as shifts: 64 + 32 + 4.
  assign w_highExt  = {7'd0, r_hcnt};
  assign w_scaled   = (w_highExt << 6) + (w_highExt << 5) + (w_highExt << 2);
  assign w_remShift = {r_rem, r_dvd[DVD_W-1]};
  assign w_ge       = (w_remShift >= {1'b0, r_divisor});
  assign w_remSub   = w_remShift[CNT_WIDTH-1:0] - r_divisor;
  assign w_remNext  = w_ge ? w_remSub : w_remShift[CNT_WIDTH-1:0];
  assign w_quoNext  = {r_dvd[DVD_W-2:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvd      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_pendHigh <= '0;
      r_iter     <= '0;
    end else if (!enable) begin
      r_dvd      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_pendHigh <= '0;
      r_iter     <= '0;
    end else if (w_load) begin
      r_dvd      <= w_scaled;
      r_rem      <= '0;
      r_divisor  <= r_cnt;
      r_pendHigh <= r_hcnt;
      r_iter     <= '0;
    end else if (w_divStep) begin
      r_dvd  <= w_quoNext;
      r_rem  <= w_remNext;
      r_iter <= r_iter + ITER_W'(1);
    end
  end

  // The last iteration's quotient goes straight to duty_pct so all outputs move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        timeout <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (w_divDone) begin
          period     <= r_divisor;
          high_time  <= r_pendHigh;
          duty_pct   <= w_quoNext[6:0];
          meas_valid <= 1'b1;
        end
        if (w_timeoutHit) begin
          period     <= '0;
          high_time  <= '0;
          duty_pct   <= w_s ? 7'd100 : 7'd0;
          timeout    <= 1'b1;
          meas_valid <= 1'b1;
        end
        if (w_overrunHit) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance for measurement behaviour and an
// 8-bit instance so the timeout cases complete in a few hundred cycles.
module tb_pwm_capture;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pwmIn;
  logic [15:0] periodOut;
  logic [15:0] highOut;
  logic [6:0]  dutyOut;
  logic        validOut;
  logic        timeoutOut;
  logic        overrunOut;

  logic        enableTo;
  logic        pwmInTo;
  logic [7:0]  periodTo;
  logic [7:0]  highTo;
  logic [6:0]  dutyTo;
  logic        validTo;
  logic        timeoutTo;
  logic        overrunTo;

  int testCount;
  int failCount;
  int cycleNum;
  int validCount;
  int validCountTo;
  int firstValidCycle;
  int lastValidCycle;
  int minGap;
  int riseQ[$];

  pwm_capture #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwmIn),
    .period(periodOut), .high_time(highOut), .duty_pct(dutyOut),
    .meas_valid(validOut), .timeout(timeoutOut), .overrun(overrunOut)
  );

  pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dutTo (
    .clk(clk), .reset(reset), .enable(enableTo), .pwm_in(pwmInTo),
    .period(periodTo), .high_time(highTo), .duty_pct(dutyTo),
    .meas_valid(validTo), .timeout(timeoutTo), .overrun(overrunTo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: outputs are sampled 1ns after the edge, and meas_valid pulses are logged.
  task automatic tick();
    @(posedge clk);
    #1;
    cycleNum++;
    if (validOut === 1'b1) begin
      validCount++;
      if (firstValidCycle < 0) firstValidCycle = cycleNum;
      if (lastValidCycle >= 0 && (cycleNum - lastValidCycle) < minGap) minGap = cycleNum - lastValidCycle;
      lastValidCycle = cycleNum;
    end
    if (validTo === 1'b1) validCountTo++;
  endtask

  task automatic resetCounts();
    validCount      = 0;
    validCountTo    = 0;
    firstValidCycle = -1;
    lastValidCycle  = -1;
    minGap          = 1000000;
    riseQ.delete();
  endtask

  task automatic applyStimulus(input int perCycles, input int highCycles, input int numPeriods);
    for (int p = 0; p < numPeriods; p++) begin
      for (int c = 0; c < perCycles; c++) begin
        pwmIn = (c < highCycles);
        if (c == 0) riseQ.push_back(cycleNum + 1);
        tick();
      end
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    cycleNum  = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    pwmIn     = 1'b0;
    enableTo  = 1'b0;
    pwmInTo   = 1'b0;
    resetCounts();
    tick();
    tick();
    checkOutput("rst_period",  periodOut,  0);
    checkOutput("rst_high",    highOut,    0);
    checkOutput("rst_duty",    dutyOut,    0);
    checkOutput("rst_valid",   validOut,   0);
    checkOutput("rst_timeout", timeoutOut, 0);
    checkOutput("rst_overrun", overrunOut, 0);

    reset    = 1'b0;
    enable   = 1'b1;
    enableTo = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // 25% duty: rise 1 arms, rises 2..4 each report 24 cycles after the detected rise,
    // which itself lags the pin by two synchronizer edges (25 ticks from the drive).
    resetCounts();
    applyStimulus(200, 50, 4);
    checkOutput("d25_count",   validCount, 3);
    checkOutput("d25_latency", firstValidCycle, riseQ[1] + 25);
    checkOutput("d25_gap",     minGap, 200);
    checkOutput("d25_period",  periodOut, 200);
    checkOutput("d25_high",    highOut, 50);
    checkOutput("d25_duty",    dutyOut, 25);

    applyStimulus(99, 67, 3);
    checkOutput("t99_period", periodOut, 99);
    checkOutput("t99_high",   highOut, 67);
    checkOutput("t99_duty",   dutyOut, 67);
    applyStimulus(300, 1, 3);
    checkOutput("t300_period", periodOut, 300);
    checkOutput("t300_high",   highOut, 1);
    checkOutput("t300_duty",   dutyOut, 0);
    applyStimulus(301, 300, 3);
    checkOutput("t301_period", periodOut, 301);
    checkOutput("t301_high",   highOut, 300);
    checkOutput("t301_duty",   dutyOut, 99);
    checkOutput("t_no_overrun", overrunOut, 0);
    checkOutput("t_no_timeout", timeoutOut, 0);

    // Overrun: period 10 is shorter than the divide, so only every third rise is latched.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    resetCounts();
    applyStimulus(10, 5, 10);
    checkOutput("ovr_count",  validCount, 3);
    checkOutput("ovr_gap",    minGap, 30);
    checkOutput("ovr_flag",   overrunOut, 1);
    checkOutput("ovr_period", periodOut, 10);
    checkOutput("ovr_high",   highOut, 5);
    checkOutput("ovr_duty",   dutyOut, 50);

    // Drop enable in the middle of a divide; the 200/50 result must hold, nothing reported.
    applyStimulus(200, 50, 2);
    applyStimulus(150, 30, 1);
    resetCounts();
    for (int c = 0; c < 150; c++) begin
      pwmIn = (c < 30);
      if (c == 12) enable = 1'b0;
      tick();
    end
    checkOutput("en_no_valid", validCount, 0);
    checkOutput("en_overrun",  overrunOut, 0);
    checkOutput("en_timeout",  timeoutOut, 0);
    checkOutput("en_period",   periodOut, 200);
    checkOutput("en_high",     highOut, 50);
    checkOutput("en_duty",     dutyOut, 25);

    enable = 1'b1;
    resetCounts();
    applyStimulus(120, 90, 2);
    checkOutput("reen_count",   validCount, 1);
    checkOutput("reen_latency", firstValidCycle, riseQ[1] + 25);
    checkOutput("reen_period",  periodOut, 120);
    checkOutput("reen_high",    highOut, 90);
    checkOutput("reen_duty",    dutyOut, 75);

    // Asynchronous reset between edges must clear outputs before the next clock.
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_period", periodOut, 0);
    checkOutput("arst_high",   highOut, 0);
    checkOutput("arst_duty",   dutyOut, 0);
    tick();
    reset = 1'b0;
    tick();

    // Sub-cycle glitches: one between edges, one straddling an edge.
    resetCounts();
    #4;
    pwmIn = 1'b1;
    #2;
    pwmIn = 1'b0;
    #2;
    pwmIn = 1'b1;
    #2;
    pwmIn = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("glitch_no_x", {31'd0, $isunknown({periodOut, highOut, dutyOut, validOut, timeoutOut, overrunOut})}, 0);
    checkOutput("glitch_no_valid", validCount, 0);

    // Timeout with input held high on the 8-bit instance (limit 255 cycles).
    resetCounts();
    pwmInTo = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    checkOutput("toh_count",  validCountTo, 1);
    checkOutput("toh_flag",   timeoutTo, 1);
    checkOutput("toh_period", periodTo, 0);
    checkOutput("toh_high",   highTo, 0);
    checkOutput("toh_duty",   dutyTo, 100);

    // Back in IDLE, so the next single edge only arms the measurement.
    resetCounts();
    pwmInTo = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    pwmInTo = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pwmInTo = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checkOutput("toh_idle", validCountTo, 0);

    enableTo = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("to_clear", timeoutTo, 0);
    enableTo = 1'b1;
    resetCounts();
    pwmInTo = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pwmInTo = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    checkOutput("tol_count",  validCountTo, 1);
    checkOutput("tol_flag",   timeoutTo, 1);
    checkOutput("tol_period", periodTo, 0);
    checkOutput("tol_duty",   dutyTo, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
